sram_axi_arbiter: RTL and testbench
===================================

Name: sram_axi_arbiter

Overview:
- Shares one AXI3 master port between two SRAM-like masters (req/addr_ok/data_ok): the instruction port (read-only, driven by the pre-IF stage) and the data port (read/write, driven by EX/MEM).
- Sits between the CPU core and the SoC AXI interconnect.
- Converts each accepted SRAM-like request into a single-beat AXI transaction.
- Guarantees exactly one data_ok per accepted request, including requests the core has since flushed.

Parameters:
- INST_ID, 4'd0, ARID used for instruction reads.
- DATA_ID, 4'd1, ARID/AWID used for data accesses.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- inst_sram_req/wr/size/wstrb/addr/wdata  input  1/1/2/4/32/32  instruction request; wr is always 0
- inst_sram_addr_ok  output  1  instruction request accepted this cycle
- inst_sram_data_ok  output  1  instruction read data valid
- inst_sram_rdata  output  32  instruction read data
- data_sram_req/wr/size/wstrb/addr/wdata  input  1/1/2/4/32/32  data request
- data_sram_addr_ok  output  1  data request accepted
- data_sram_data_ok  output  1  data read returned or write acknowledged
- data_sram_rdata  output  32  data read data
- arid/araddr/arsize/arvalid  output  4/32/3/1  AR channel
- arready  input  1  AR handshake
- arlen/arburst/arlock/arcache/arprot  output  8/2/2/4/3  constants 0/2'b01/0/0/0
- rid/rdata/rresp/rlast/rvalid  input  4/32/2/1/1  R channel
- rready  output  1  R ready
- awid/awaddr/awsize/awvalid  output  4/32/3/1  AW channel
- awready  input  1  AW handshake
- awlen/awburst/awlock/awcache/awprot  output  8/2/2/4/3  same constants as AR
- wid/wdata/wstrb/wlast/wvalid  output  4/32/4/1/1  W channel; wlast=1
- wready  input  1  W handshake
- bid/bresp/bvalid  input  4/2/1  B channel
- bready  output  1  B ready

Behaviour:
- Reset values: all *valid 0, addr_ok/data_ok 0, all outstanding flags 0, rready 1, bready 1.
- Outstanding limits:
  - Instruction port: at most 1 read outstanding (flag inst_busy).
  - Data port: at most 1 transaction of either kind outstanding (flag data_busy). Data responses are therefore in order, and a read and a write never complete in the same cycle.
- AR FSM states:
  - AR_IDLE: grant when arvalid is low. A data read (data_sram_req & ~wr & ~data_busy) beats an instruction read (inst_sram_req & ~inst_busy).
  - On grant: assert the winner's addr_ok combinationally in that cycle; latch addr, {1'b0,size}→arsize and the ID; set the winner's busy flag; go to AR_SEND.
  - AR_SEND: arvalid=1 with registered fields held stable. On arready go to AR_IDLE. An AR_IDLE grant can occur in the cycle after the handshake.
- Write path:
  - Data write (data_sram_req & wr & ~data_busy) is accepted in a cycle with no data-read grant.
  - On acceptance: addr_ok=1; set data_busy; register awaddr, awsize, wdata, wstrb.
  - Next cycle: assert awvalid and wvalid together. Each drops independently on its own handshake.
  - A write may be accepted in the same cycle as an instruction-read grant.
- R channel:
  - rid==INST_ID & rvalid: inst_sram_data_ok=1, inst_sram_rdata=rdata (combinational pass-through), clear inst_busy.
  - rid==DATA_ID & rvalid: same on the data port, clear data_busy.
- B channel: bvalid & bid==DATA_ID → data_sram_data_ok=1, clear data_busy.
- Busy-flag timing: a flag is cleared on the response cycle, and the same port may be granted a new request in that same cycle (flag clear has priority over the busy check, via next-state logic).
- rresp/bresp are ignored.
- A pending but un-granted request keeps addr_ok=0. Masters must hold req and fields until addr_ok.
- Reset mid-operation clears all state. Responses arriving after reset are not expected, because the interconnect shares the same reset.

Decomposition:
- Shared package/header `include "mycpu.h"` holds:
  - AXI fixed-field constants: LEN 0, BURST INCR, LOCK/CACHE/PROT 0.
  - INST_ID and DATA_ID defaults.
  - AR FSM state encodings.
- Single module. No sub-module is needed.

Test Plan:
- Reset: hold reset 3 cycles, then release → all valid/addr_ok/data_ok 0, rready=bready=1.
- Instruction read: inst req addr 0x1C000000, arready=1 → addr_ok same cycle; next cycle arvalid with arid 0, araddr 0x1C000000, arsize 3'b010; rvalid rid0 rdata 0x02800000 → inst data_ok with that data.
- Contention: inst and data reads requested in the same cycle (data addr 0x1C008000) → data wins with arid 1. Inst addr_ok comes in a later cycle, after the data AR handshake. rid1 then rid0 return out of order and route correctly.
- Write: data write addr 0x1C009000, wdata 0xDEADBEEF, wstrb 4'b0011, awready delayed 2 cycles, wready immediate → wvalid drops after 1 cycle, awvalid after 3. bvalid → data_ok. A second data request is stalled until then.
- Back-to-back: data_ok for a data read in cycle N, new data write req held → addr_ok in cycle N.
- Flushed fetch: instruction read accepted; core deasserts req. rvalid 20 cycles later → inst data_ok still pulses exactly once, and no extra AR is issued.

Source files
------------

// File: rtl/sram_axi_arbiter_pkg.sv
// Shared constants and types for the SRAM-like to AXI3 arbiter.
// Covers the fixed AXI fields, the default transaction IDs and the AR FSM encodings.
package sram_axi_arbiter_pkg;

  localparam logic [7:0] AXI_LEN        = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK       = 2'b00;
  localparam logic [3:0] AXI_CACHE      = 4'b0000;
  localparam logic [2:0] AXI_PROT       = 3'b000;

  localparam logic [3:0] INST_ID_DEFAULT = 4'd0;
  localparam logic [3:0] DATA_ID_DEFAULT = 4'd1;

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_SEND = 1'b1;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_req_t;

endpackage

// File: rtl/sram_axi_arbiter.sv
// Shares one single-beat AXI3 master between an instruction (read-only) and a data SRAM-like port.
// Each port keeps at most one transaction in flight; responses are steered back by ID.
module sram_axi_arbiter
  import sram_axi_arbiter_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEFAULT,
  parameter logic [3:0] DATA_ID = DATA_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  logic [0:0]  ar_state_q, ar_state_d;
  ar_req_t     ar_req_q, ar_req_d;
  logic        inst_busy_q, inst_busy_d;
  logic        data_busy_q, data_busy_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic inst_r_hit, data_r_hit, data_b_hit;
  logic inst_free, data_free, ar_idle;
  logic data_rd_grant, inst_rd_grant, data_wr_accept;

  // Write-only and response-status inputs carry no information this block needs.
  logic unused_ok;
  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bresp};

  assign inst_r_hit = rvalid & (rid == INST_ID);
  assign data_r_hit = rvalid & (rid == DATA_ID);
  assign data_b_hit = bvalid & (bid == DATA_ID);

  // A response retiring in this cycle frees its port for a new grant in the same cycle.
  assign inst_free = ~inst_busy_q | inst_r_hit;
  assign data_free = ~data_busy_q | data_r_hit | data_b_hit;
  assign ar_idle   = (ar_state_q == AR_IDLE);

  assign data_rd_grant  = ar_idle & data_sram_req & ~data_sram_wr & data_free;
  assign inst_rd_grant  = ar_idle & inst_sram_req & inst_free & ~data_rd_grant;
  assign data_wr_accept = data_sram_req & data_sram_wr & data_free;

  always_comb begin
    ar_state_d  = ar_state_q;
    ar_req_d    = ar_req_q;
    inst_busy_d = inst_busy_q & ~inst_r_hit;
    data_busy_d = data_busy_q & ~(data_r_hit | data_b_hit);
    awvalid_d   = awvalid_q & ~awready;
    wvalid_d    = wvalid_q & ~wready;
    awaddr_d    = awaddr_q;
    awsize_d    = awsize_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;

    if (ar_state_q == AR_SEND && arready) begin
      ar_state_d = AR_IDLE;
    end
    if (data_rd_grant) begin
      ar_state_d  = AR_SEND;
      ar_req_d    = '{id: DATA_ID, addr: data_sram_addr, size: {1'b0, data_sram_size}};
      data_busy_d = 1'b1;
    end else if (inst_rd_grant) begin
      ar_state_d  = AR_SEND;
      ar_req_d    = '{id: INST_ID, addr: inst_sram_addr, size: {1'b0, inst_sram_size}};
      inst_busy_d = 1'b1;
    end

    if (data_wr_accept) begin
      data_busy_d = 1'b1;
      awvalid_d   = 1'b1;
      wvalid_d    = 1'b1;
      awaddr_d    = data_sram_addr;
      awsize_d    = {1'b0, data_sram_size};
      wdata_d     = data_sram_wdata;
      wstrb_d     = data_sram_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state_q  <= AR_IDLE;
      ar_req_q    <= '0;
      inst_busy_q <= 1'b0;
      data_busy_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      awaddr_q    <= '0;
      awsize_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      ar_state_q  <= ar_state_d;
      ar_req_q    <= ar_req_d;
      inst_busy_q <= inst_busy_d;
      data_busy_q <= data_busy_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      awaddr_q    <= awaddr_d;
      awsize_q    <= awsize_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  assign inst_sram_addr_ok = inst_rd_grant;
  assign inst_sram_data_ok = inst_r_hit;
  assign inst_sram_rdata   = rdata;
  assign data_sram_addr_ok = data_rd_grant | data_wr_accept;
  assign data_sram_data_ok = data_r_hit | data_b_hit;
  assign data_sram_rdata   = rdata;

  assign arid    = ar_req_q.id;
  assign araddr  = ar_req_q.addr;
  assign arsize  = ar_req_q.size;
  assign arvalid = (ar_state_q == AR_SEND);
  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign rready  = 1'b1;

  assign awid    = DATA_ID;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;

  assign wid    = DATA_ID;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;
  assign wvalid = wvalid_q;
  assign bready = 1'b1;

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Bench for sram_axi_arbiter: directed scenarios with literal expectations, then randomized
// traffic from two masters and a responsive AXI slave, all checked by a transaction-level model.
module tb_sram_axi_arbiter;

  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;
  localparam logic [18:0] AX_CONST = {8'd0, 2'b01, 2'b00, 4'b0000, 3'b000};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sram_axi_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance to the drive slot just after the active edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; awready = 0; wready = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    bid = 0; bresp = 0; bvalid = 0;
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } beat_t;

  beat_t       ar_pending[$];
  bit          inst_outstanding, data_outstanding;
  bit          aw_owed, w_owed;
  beat_t       aw_beat;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  initial begin : model_compare
    bit inst_ret, data_ret, can_i, can_d, grant_dr, grant_dw, grant_ir;
    forever begin
      @(negedge clk);
      if (reset) begin
        ar_pending.delete();
        inst_outstanding = 0; data_outstanding = 0; aw_owed = 0; w_owed = 0;
      end else begin
        inst_ret = rvalid && rid == INST_ID;
        data_ret = (rvalid && rid == DATA_ID) || (bvalid && bid == DATA_ID);
        can_i    = inst_sram_req && (!inst_outstanding || inst_ret);
        can_d    = data_sram_req && (!data_outstanding || data_ret);
        grant_dr = can_d && !data_sram_wr && ar_pending.size() == 0;
        grant_dw = can_d && data_sram_wr;
        grant_ir = can_i && ar_pending.size() == 0 && !grant_dr;

        checkOutput("m_inst_addr_ok", inst_sram_addr_ok, grant_ir);
        checkOutput("m_data_addr_ok", data_sram_addr_ok, grant_dr || grant_dw);
        checkOutput("m_inst_data_ok", inst_sram_data_ok, inst_ret);
        checkOutput("m_data_data_ok", data_sram_data_ok, data_ret);
        if (inst_ret) checkOutput("m_inst_rdata", inst_sram_rdata, rdata);
        if (rvalid && rid == DATA_ID) checkOutput("m_data_rdata", data_sram_rdata, rdata);
        checkOutput("m_arvalid", arvalid, ar_pending.size() != 0);
        if (ar_pending.size() != 0)
          checkOutput("m_ar_fields", {arid, araddr, arsize},
                      {ar_pending[0].id, ar_pending[0].addr, ar_pending[0].size});
        checkOutput("m_awvalid", awvalid, aw_owed);
        checkOutput("m_wvalid", wvalid, w_owed);
        if (aw_owed) checkOutput("m_aw_fields", {awid, awaddr, awsize}, {DATA_ID, aw_beat.addr, aw_beat.size});
        if (w_owed) checkOutput("m_w_fields", {wid, wdata, wstrb, wlast}, {DATA_ID, w_data, w_strb, 1'b1});
        checkOutput("m_fixed", {arlen, arburst, arlock, arcache, arprot, awlen, awburst, awlock,
                                awcache, awprot, rready, bready}, {AX_CONST, AX_CONST, 2'b11});

        if (ar_pending.size() != 0 && arready) void'(ar_pending.pop_front());
        if (grant_dr) ar_pending.push_back('{DATA_ID, data_sram_addr, {1'b0, data_sram_size}});
        if (grant_ir) ar_pending.push_back('{INST_ID, inst_sram_addr, {1'b0, inst_sram_size}});
        if (aw_owed && awready) aw_owed = 0;
        if (w_owed && wready) w_owed = 0;
        if (grant_dw) begin
          aw_owed = 1; w_owed = 1;
          aw_beat = '{DATA_ID, data_sram_addr, {1'b0, data_sram_size}};
          w_data  = data_sram_wdata;
          w_strb  = data_sram_wstrb;
        end
        inst_outstanding = (inst_outstanding && !inst_ret) || grant_ir;
        data_outstanding = (data_outstanding && !data_ret) || grant_dr || grant_dw;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed scenarios, then randomized traffic ----------------
  initial begin : stimulus
    int ar_seen, aok_seen, dok_seen, n_resp;
    bit i_pend, d_pend, d_wr, got_aw, got_w, b_pend;
    bit r_pend[2];
    int r_wait[2];
    int b_wait;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic [1:0]  d_size;
    bit s_iaok, s_daok, s_arhs, s_awhs, s_whs, s_rhs, s_bhs;
    logic [3:0] s_arid, s_rid;

    idleInputs();
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    checkOutput("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    checkOutput("rst_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b00);
    checkOutput("rst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 2'b00);
    checkOutput("rst_readies", {rready, bready}, 2'b11);

    // Single instruction fetch.
    applyStimulus();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000; arready = 1;
    @(negedge clk);
    checkOutput("if_addr_ok", inst_sram_addr_ok, 1'b1);
    checkOutput("if_arvalid_early", arvalid, 1'b0);
    applyStimulus();
    inst_sram_req = 0;
    @(negedge clk);
    checkOutput("if_ar", {arvalid, arid, araddr, arsize}, {1'b1, 4'd0, 32'h1C00_0000, 3'b010});
    applyStimulus();
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h0280_0000;
    @(negedge clk);
    checkOutput("if_data_ok", {inst_sram_data_ok, data_sram_data_ok, arvalid}, 3'b100);
    checkOutput("if_rdata", inst_sram_rdata, 32'h0280_0000);

    // Contention: data read wins, instruction read follows after the AR handshake.
    applyStimulus();
    rvalid = 0;
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0010;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1C00_8000;
    @(negedge clk);
    checkOutput("ct_grant", {data_sram_addr_ok, inst_sram_addr_ok}, 2'b10);
    applyStimulus();
    data_sram_req = 0;
    @(negedge clk);
    checkOutput("ct_data_ar", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h1C00_8000});
    checkOutput("ct_inst_wait", inst_sram_addr_ok, 1'b0);
    applyStimulus();
    arready = 1;
    @(negedge clk);
    checkOutput("ct_inst_wait2", inst_sram_addr_ok, 1'b0);
    applyStimulus();
    @(negedge clk);
    checkOutput("ct_inst_grant", {inst_sram_addr_ok, arvalid}, 2'b10);
    applyStimulus();
    inst_sram_req = 0;
    @(negedge clk);
    checkOutput("ct_inst_ar", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h1C00_0010});
    applyStimulus();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h1111_1111;
    @(negedge clk);
    checkOutput("ct_rid1", {data_sram_data_ok, inst_sram_data_ok, data_sram_rdata}, {2'b10, 32'h1111_1111});
    applyStimulus();
    rid = 4'd0; rdata = 32'h2222_2222;
    @(negedge clk);
    checkOutput("ct_rid0", {data_sram_data_ok, inst_sram_data_ok, inst_sram_rdata}, {2'b01, 32'h2222_2222});

    // Data write with a late awready; a following read is stalled until the B response.
    applyStimulus();
    rvalid = 0;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1C00_9000;
    data_sram_wdata = 32'hDEAD_BEEF; data_sram_wstrb = 4'b0011; wready = 1;
    @(negedge clk);
    checkOutput("wr_addr_ok", {data_sram_addr_ok, awvalid, wvalid}, 3'b100);
    applyStimulus();
    data_sram_wr = 0; data_sram_addr = 32'h1C00_A000; data_sram_wdata = 0; data_sram_wstrb = 0;
    @(negedge clk);
    checkOutput("wr_valids", {awvalid, wvalid, data_sram_addr_ok}, 3'b110);
    checkOutput("wr_fields", {awid, awaddr, awsize, wdata, wstrb, wlast},
                {4'd1, 32'h1C00_9000, 3'b010, 32'hDEAD_BEEF, 4'b0011, 1'b1});
    applyStimulus();
    @(negedge clk);
    checkOutput("wr_w_drop", {awvalid, wvalid, data_sram_addr_ok}, 3'b100);
    applyStimulus();
    awready = 1;
    @(negedge clk);
    checkOutput("wr_aw_hold", awvalid, 1'b1);
    applyStimulus();
    awready = 0; wready = 0;
    @(negedge clk);
    checkOutput("wr_aw_drop", {awvalid, data_sram_addr_ok}, 2'b00);
    applyStimulus();
    bvalid = 1; bid = 4'd1;
    @(negedge clk);
    checkOutput("wr_b_and_next", {data_sram_data_ok, data_sram_addr_ok}, 2'b11);
    applyStimulus();
    bvalid = 0; data_sram_req = 0; arready = 1;
    @(negedge clk);
    checkOutput("wr_next_ar", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h1C00_A000});

    // Back-to-back: a held write is accepted in the same cycle the read returns.
    applyStimulus();
    arready = 0;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1C00_B000;
    data_sram_wdata = 32'hCAFE_F00D; data_sram_wstrb = 4'hF;
    @(negedge clk);
    checkOutput("bb_stall", data_sram_addr_ok, 1'b0);
    applyStimulus();
    rvalid = 1; rid = 4'd1; rdata = 32'h3333_3333;
    @(negedge clk);
    checkOutput("bb_same_cycle", {data_sram_data_ok, data_sram_addr_ok, data_sram_rdata}, {2'b11, 32'h3333_3333});
    applyStimulus();
    rvalid = 0; data_sram_req = 0; awready = 1; wready = 1;
    @(negedge clk);
    checkOutput("bb_aw", {awvalid, wvalid, awaddr}, {2'b11, 32'h1C00_B000});
    applyStimulus();
    awready = 0; wready = 0;
    @(negedge clk);
    checkOutput("bb_aw_done", {awvalid, wvalid}, 2'b00);
    applyStimulus();
    bvalid = 1;
    @(negedge clk);
    checkOutput("bb_b", data_sram_data_ok, 1'b1);

    // Flushed fetch: the response still arrives once; a refetch waits for it.
    applyStimulus();
    bvalid = 0; inst_sram_req = 1; inst_sram_addr = 32'h1C00_0040; arready = 1;
    @(negedge clk);
    checkOutput("fl_addr_ok", inst_sram_addr_ok, 1'b1);
    applyStimulus();
    inst_sram_req = 0;
    @(negedge clk);
    checkOutput("fl_ar", {arvalid, araddr}, {1'b1, 32'h1C00_0040});
    applyStimulus();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0080;
    ar_seen = 0; aok_seen = 0; dok_seen = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      ar_seen += int'(arvalid); aok_seen += int'(inst_sram_addr_ok); dok_seen += int'(inst_sram_data_ok);
      applyStimulus();
    end
    checkOutput("fl_quiet", {ar_seen[7:0], aok_seen[7:0], dok_seen[7:0]}, 24'd0);
    rvalid = 1; rid = 4'd0; rdata = 32'h4444_4444;
    @(negedge clk);
    checkOutput("fl_late_resp", {inst_sram_data_ok, inst_sram_addr_ok, inst_sram_rdata}, {2'b11, 32'h4444_4444});
    applyStimulus();
    rvalid = 0; inst_sram_req = 0;
    @(negedge clk);
    checkOutput("fl_once", {inst_sram_data_ok, arvalid, araddr}, {2'b01, 32'h1C00_0080});
    applyStimulus();
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h5555_5555;
    @(negedge clk);
    checkOutput("fl_refetch", inst_sram_data_ok, 1'b1);
    applyStimulus();
    rvalid = 0;

    // Randomized traffic with a mid-run reset.
    $display("[TB] directed scenarios done, starting random traffic");
    i_pend = 0; d_pend = 0; got_aw = 0; got_w = 0; b_pend = 0; b_wait = 0;
    r_pend[0] = 0; r_pend[1] = 0; r_wait[0] = 0; r_wait[1] = 0; n_resp = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; d_size = 0; d_wr = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      s_iaok = inst_sram_addr_ok; s_daok = data_sram_addr_ok;
      s_arhs = arvalid && arready; s_arid = arid;
      s_awhs = awvalid && awready; s_whs = wvalid && wready;
      s_rhs = rvalid && rready; s_rid = rid; s_bhs = bvalid && bready;
      applyStimulus();
      if (cyc == 700 || cyc == 701) begin
        reset = 1;
        idleInputs();
        i_pend = 0; d_pend = 0; got_aw = 0; got_w = 0; b_pend = 0;
        r_pend[0] = 0; r_pend[1] = 0;
        continue;
      end
      reset = 0;
      if (s_iaok) i_pend = 0;
      if (s_daok) d_pend = 0;
      if (s_rhs) begin r_pend[s_rid[0]] = 0; n_resp++; end
      if (s_arhs) begin r_pend[s_arid[0]] = 1; r_wait[s_arid[0]] = $urandom_range(0, 5); end
      if (s_awhs) got_aw = 1;
      if (s_whs) got_w = 1;
      if (s_bhs) begin got_aw = 0; got_w = 0; b_pend = 0; n_resp++; end
      for (int k = 0; k < 2; k++) if (r_pend[k] && r_wait[k] > 0) r_wait[k]--;

      rvalid = 0;
      if (r_pend[0] && r_wait[0] == 0 && (!(r_pend[1] && r_wait[1] == 0) || $urandom_range(0, 1) == 0)) begin
        rvalid = 1; rid = INST_ID;
      end else if (r_pend[1] && r_wait[1] == 0) begin
        rvalid = 1; rid = DATA_ID;
      end
      rdata = $urandom; rresp = 2'($urandom); rlast = 1;

      if (got_aw && got_w && !b_pend) begin b_pend = 1; b_wait = $urandom_range(0, 4); end
      else if (b_pend && b_wait > 0) b_wait--;
      bvalid = b_pend && b_wait == 0; bid = DATA_ID; bresp = 2'($urandom);

      if (!i_pend && $urandom_range(0, 2) == 0) begin i_pend = 1; i_addr = $urandom & 32'hFFFF_FFFC; end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_wr = 1'($urandom); d_addr = $urandom; d_size = 2'($urandom_range(0, 2));
        d_wdata = $urandom; d_wstrb = 4'($urandom);
      end
      inst_sram_req = i_pend; inst_sram_addr = i_pend ? i_addr : $urandom; inst_sram_size = 2'd2;
      data_sram_req = d_pend; data_sram_wr = d_wr; data_sram_addr = d_addr; data_sram_size = d_size;
      data_sram_wdata = d_wdata; data_sram_wstrb = d_wstrb;
      arready = $urandom_range(0, 3) != 0;
      awready = 1'($urandom);
      wready = 1'($urandom);
    end
    applyStimulus();
    idleInputs();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rand_traffic", n_resp > 100, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
